// File: rtl/mult_arbiter_if.sv
// Request/response bus between two requesters and the multiplier sequencer.
//   req_valid[i]  requester i has an operand pair pending
//   req_ready[i]  grant/accept strobe for requester i (combinational)
//   req_a*/req_b* signed multiplicand/multiplier of each requester
//   rsp_valid[i]  rsp_y holds requester i's product
//   rsp_ready[i]  requester i accepts the product
//   rsp_y         signed 2*WIDTH product
interface mult_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   req_a0;
    logic [WIDTH-1:0]   req_b0;
    logic [WIDTH-1:0]   req_a1;
    logic [WIDTH-1:0]   req_b1;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [2*WIDTH-1:0] rsp_y;

    // Requester side
    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_y
    );

    // Arbiter/sequencer side
    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/mult_arbiter_ctrl.sv
// Round-robin arbiter and step sequencer for a shared signed shift-add
// multiplier datapath. Grants one of two requesters, drives load/add/sub/shift
// strobes over WIDTH add-shift steps, captures the product and returns it to
// the granted requester.
//   clk, rst_n   clock (rising edge), async active-low reset
//   bus          request/response bus (slave side)
//   dp_s, dp_b   registered operands to the datapath
//   dp_load/add/sub/shift  datapath strobes, one-hot or idle
//   dp_m         datapath current B[0]
//   dp_y         datapath {A,B}
//   busy         high whenever not idle
//   count        current step index, 0 outside the add/shift loop
module mult_arbiter_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_arbiter_if.slave        bus,
    output logic [WIDTH-1:0]     dp_s,
    output logic [WIDTH-1:0]     dp_b,
    output logic                 dp_load,
    output logic                 dp_add,
    output logic                 dp_sub,
    output logic                 dp_shift,
    input  logic                 dp_m,
    input  logic [2*WIDTH-1:0]   dp_y,
    output logic                 busy,
    output logic [3:0]           count
);
    localparam int unsigned CW   = 4;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        CAPT,
        RESP
    } state_t;

    state_t         state;
    logic           grant;       // requester owning the current operation
    logic           last_grant;  // fairness pointer
    logic [PW-1:0]  rsp_y;
    logic [1:0]     win_c;       // one-hot grant decision in IDLE

    // Grant decision: single requester wins outright, a tie goes to ~last_grant.
    // Gated by rst_n so no grant is offered while reset is held.
    always_comb begin
        win_c = 2'b00;
        if (state == IDLE && rst_n) begin
            case (bus.req_valid)
                2'b01:   win_c = 2'b01;
                2'b10:   win_c = 2'b10;
                2'b11:   win_c = last_grant ? 2'b01 : 2'b10;
                default: win_c = 2'b00;
            endcase
        end
    end

    assign bus.req_ready = win_c;

    // Strobes decode from the state register; add/sub also need the live
    // multiplier bit, which is only valid once the previous shift has landed.
    assign dp_load  = (state == LOAD);
    assign dp_add   = (state == ADD) && dp_m && (count != LAST);
    assign dp_sub   = (state == ADD) && dp_m && (count == LAST);
    assign dp_shift = (state == SHIFT);

    assign bus.rsp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_y     = rsp_y;

    // Sequencer state, operand latches, product capture and fairness pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= ~FIRST_PRIO;
            dp_s       <= '0;
            dp_b       <= '0;
            rsp_y      <= '0;
            busy       <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_c != 2'b00) begin
                        grant      <= win_c[1];
                        last_grant <= win_c[1];
                        dp_s       <= win_c[1] ? bus.req_a1 : bus.req_a0;
                        dp_b       <= win_c[1] ? bus.req_b1 : bus.req_b0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    count <= '0;
                    state <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (count != LAST) begin
                        count <= count + CW'(1);
                        state <= ADD;
                    end else begin
                        count <= '0;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    rsp_y <= dp_y;
                    state <= RESP;
                end
                RESP: begin
                    // Only the owning requester's ready completes delivery
                    if (bus.rsp_ready[grant]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
